fp_div: RTL and testbench

Sequential IEEE-754 single-precision divider. It is the inverse-operation companion of the existing add/multiply floating-point datapath and its control unit. The block takes two packed 32-bit operands under a start/done handshake and runs a restoring mantissa division, one quotient bit per clock. It then normalizes, rounds to nearest-even and repacks the result in the same format the adder/multiplier produces. Denormal inputs and results are flushed to zero.

---
 rtl/fp_pkg.sv | 24 ++
 rtl/fp_unpack.sv | 23 ++
 rtl/fp_div.sv | 192 +++++++++++++++++++
 tb/tb_fp_div.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state codes and the operand class record
// used by the divider and the add/multiply datapath.
package fp_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam int          FRAC_W   = 23;
  localparam int          MANT_W   = 24;
  localparam int          QUOT_W   = 26;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_DIVIDE = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational field split and classifier for one packed single-precision operand.
// Denormals classify as zero; the hidden 1 is always prepended.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       x,
  output logic              sgn,
  output logic [7:0]        expo,
  output logic [MANT_W-1:0] mant,
  output fp_class_t         cls
);

  logic [FRAC_W-1:0] frac;

  assign sgn         = x[31];
  assign expo        = x[30:23];
  assign frac        = x[FRAC_W-1:0];
  assign mant        = {1'b1, frac};
  assign cls.is_zero = (expo == 8'h00);
  assign cls.is_inf  = (expo == 8'hFF) && (frac == '0);
  assign cls.is_nan  = (expo == 8'hFF) && (frac != '0);

endmodule

// File: rtl/fp_div.sv
// Sequential single-precision divider: restoring division one quotient bit per clock,
// then round-to-nearest-even and repack. Normal latency 29 clocks, specials 2 clocks.
module fp_div
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  localparam logic signed [9:0] E_BIAS = 10'(EXP_BIAS);
  localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);

  logic [2:0]              state_q, state_d;
  logic [31:0]             a_q, a_d, b_q, b_d;
  logic                    sign_q, sign_d;
  logic signed [9:0]       e_q, e_d;
  logic [MANT_W:0]         r_q, r_d;
  logic [MANT_W-1:0]       mb_q, mb_d;
  logic [QUOT_W-1:0]       q_q, q_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [31:0]             result_q, result_d;
  logic                    invalid_q, invalid_d, dbz_q, dbz_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d;

  logic              sa, sb;
  logic [7:0]        ea, eb;
  logic [MANT_W-1:0] ma, mbn;
  fp_class_t         ca, cb;

  fp_unpack u_unpack_a (.x(a_q), .sgn(sa), .expo(ea), .mant(ma),  .cls(ca));
  fp_unpack u_unpack_b (.x(b_q), .sgn(sb), .expo(eb), .mant(mbn), .cls(cb));

  logic              ge;
  logic [MANT_W:0]   diff;
  logic [MANT_W-1:0] pre_mant, rnd_mant;
  logic              guard, sticky;
  logic [MANT_W:0]   rnd_sum;
  logic signed [9:0] pre_e, rnd_e;

  always_comb begin
    ge   = (r_q >= {1'b0, mb_q});
    diff = ge ? (r_q - {1'b0, mb_q}) : r_q;
  end

  // Quotient lies in (0.5, 2): normalise by at most one position before rounding.
  always_comb begin
    if (q_q[QUOT_W-1]) begin
      pre_mant = q_q[QUOT_W-1:2];
      guard    = q_q[1];
      sticky   = q_q[0] | (r_q != '0);
      pre_e    = e_q;
    end else begin
      pre_mant = q_q[QUOT_W-2:1];
      guard    = q_q[0];
      sticky   = (r_q != '0);
      pre_e    = e_q - 10'sd1;
    end
    rnd_sum = {1'b0, pre_mant} + (MANT_W+1)'(guard & (sticky | pre_mant[0]));
    if (rnd_sum[MANT_W]) begin
      rnd_mant = 24'h800000;
      rnd_e    = pre_e + 10'sd1;
    end else begin
      rnd_mant = rnd_sum[MANT_W-1:0];
      rnd_e    = pre_e;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    e_d       = e_q;
    r_d       = r_q;
    mb_d      = mb_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    invalid_d = invalid_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          invalid_d = 1'b0;
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
          state_d   = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_d  = sa ^ sb;
        e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
        r_d     = {1'b0, ma};
        mb_d    = mbn;
        q_d     = '0;
        cnt_d   = '0;
        state_d = ST_DONE;
        if (ca.is_nan || cb.is_nan || (ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
          result_d  = QNAN;
          invalid_d = 1'b1;
        end else if (ca.is_inf) begin
          result_d = {sa ^ sb, 8'hFF, 23'd0};
        end else if (cb.is_zero) begin
          result_d = {sa ^ sb, 8'hFF, 23'd0};
          dbz_d    = 1'b1;
        end else if (ca.is_zero || cb.is_inf) begin
          result_d = {sa ^ sb, 31'd0};
        end else begin
          state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        q_d   = {q_q[QUOT_W-2:0], ge};
        r_d   = diff << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QUOT_W - 1)) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        state_d = ST_DONE;
        if (rnd_e >= E_MAX) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else if (rnd_e <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, rnd_e[7:0], rnd_mant[FRAC_W-1:0]};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      e_q       <= '0;
      r_q       <= '0;
      mb_q      <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      invalid_q <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      e_q       <= e_d;
      r_q       <= r_d;
      mb_q      <= mb_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      invalid_q <= invalid_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign invalid     = invalid_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div: directed spec vectors, randomized operands against an exact
// integer-division reference, handshake timing and mid-operation reset.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done, invalid, div_by_zero, overflow, underflow;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int LIMIT = 60;

  fp_div dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .invalid(invalid), .div_by_zero(div_by_zero),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference: exact quotient via integer division, then RNE to 24 bits.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic [3:0] fl, output int lat);
    logic        s, az, ai, an, bz, bi, bn;
    logic [63:0] num, den, qv, rm, mant;
    logic        g, st;
    int          e;
    s  = x[31] ^ y[31];
    az = (x[30:23] == 0);
    ai = (x[30:23] == 255) && (x[22:0] == 0);
    an = (x[30:23] == 255) && (x[22:0] != 0);
    bz = (y[30:23] == 0);
    bi = (y[30:23] == 255) && (y[22:0] == 0);
    bn = (y[30:23] == 255) && (y[22:0] != 0);
    fl  = 4'b0000;
    lat = 2;
    if (an || bn || (az && bz) || (ai && bi)) begin
      res = 32'h7FC00000; fl = 4'b1000;
    end else if (ai) begin
      res = {s, 8'hFF, 23'd0};
    end else if (bz) begin
      res = {s, 8'hFF, 23'd0}; fl = 4'b0100;
    end else if (az || bi) begin
      res = {s, 31'd0};
    end else begin
      lat = 29;
      num = {40'd0, 1'b1, x[22:0]} << 26;
      den = {40'd0, 1'b1, y[22:0]};
      qv  = num / den;
      rm  = num % den;
      e   = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (qv >= (64'd1 << 26)) begin
        mant = qv >> 3; g = qv[2]; st = (qv[1:0] != 0) || (rm != 0);
      end else begin
        mant = qv >> 2; g = qv[1]; st = qv[0] || (rm != 0); e = e - 1;
      end
      if (g && (st || mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin
        mant = 64'd1 << 23; e = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0}; fl = 4'b0010;
      end else if (e <= 0) begin
        res = {s, 31'd0}; fl = 4'b0001;
      end else begin
        res = {s, 8'(e), mant[22:0]};
      end
    end
  endtask

  // Drives one operation; optionally pulses a stray start at cycle pulse_at while busy.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input int pulse_at,
                        output logic [31:0] res, output logic [3:0] fl, output int cyc,
                        output logic busy_ok);
    @(negedge clk);
    a = op_a; b = op_b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == pulse_at) begin
        start = 1'b1; a = 32'h0; b = 32'h0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    start = 1'b0;
    res = result;
    fl  = {invalid, div_by_zero, overflow, underflow};
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [31:0] f;
    int          sel;
    sel = $urandom_range(0, 15);
    f   = $urandom;
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) begin
      e = 8'd255;
      if ($urandom_range(0, 1) == 0) f = 32'd0;
    end else begin
      e = 8'($urandom_range(1, 254));
      if (sel == 2) f = f & 32'h007E0000;
    end
    return {1'($urandom_range(0, 1)), e, f[22:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctl: busy/done=%b required 00", {busy, done});
    end
    n_checks++;
    if ({result, invalid, div_by_zero, overflow, underflow} !== 36'd0) begin
      n_fail++; $display("FAIL reset_out: result=%h flags=%b required 0",
                         result, {invalid, div_by_zero, overflow, underflow});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [11] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                             32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000,
                             32'h7FC00001, 32'h7F800000, 32'h40000000};
    logic [31:0] vb [11] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000,
                             32'h00000000, 32'h7F800000, 32'h3E800000, 32'h40000000,
                             32'h3F800000, 32'h40000000, 32'hFF800000};
    logic [31:0] vr [11] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'hFF800000,
                             32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                             32'h7FC00000, 32'h7F800000, 32'h80000000};
    logic [3:0]  vf [11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b1000,
                             4'b0010, 4'b0001, 4'b1000, 4'b0000, 4'b0000};
    int          vl [11] = '{29, 29, 29, 2, 2, 2, 29, 29, 2, 2, 2};
    logic [31:0] res;
    logic [3:0]  fl;
    int          cyc;
    logic        bok;
    for (int i = 0; i < 11; i++) begin
      run_op(va[i], vb[i], 0, res, fl, cyc, bok);
      n_checks++;
      if (res !== vr[i]) begin
        n_fail++; $display("FAIL dir_result[%0d]: got %h required %h", i, res, vr[i]);
      end
      n_checks++;
      if (fl !== vf[i]) begin
        n_fail++; $display("FAIL dir_flags[%0d]: got %b required %b", i, fl, vf[i]);
      end
      n_checks++;
      if (cyc !== vl[i] || bok !== 1'b1) begin
        n_fail++; $display("FAIL dir_latency[%0d]: got %0d busy_ok=%b required %0d busy_ok=1",
                           i, cyc, bok, vl[i]);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== vr[i]) begin
        n_fail++; $display("FAIL dir_pulse[%0d]: done=%b busy=%b result=%h required 0 0 %h",
                           i, done, busy, result, vr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, res, eres;
    logic [3:0]  fl, efl;
    int          cyc, elat;
    logic        bok;
    for (int i = 0; i < 200; i++) begin
      x = rand_op();
      y = rand_op();
      ref_div(x, y, eres, efl, elat);
      run_op(x, y, 0, res, fl, cyc, bok);
      n_checks++;
      if (res !== eres || fl !== efl || cyc !== elat || bok !== 1'b1) begin
        n_fail++;
        $display("FAIL rand[%0d] %h/%h: got %h %b lat %0d busy_ok=%b required %h %b lat %0d",
                 i, x, y, res, fl, cyc, bok, eres, efl, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [3:0]  fl;
    int          cyc;
    logic        bok;
    run_op(32'h3F800000, 32'h40400000, 0, res, fl, cyc, bok);
    // start held through the done cycle: must be taken only in the following idle cycle
    start = 1'b1; a = 32'hBF800000; b = 32'h00000000;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done_start: busy=%b done=%b required 0 0", busy, done);
    end
    a = 32'h40C00000; b = 32'h40000000;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 29 || result !== 32'h40400000 ||
        {invalid, div_by_zero, overflow, underflow} !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_second: lat %0d result %h flags %b required 29 40400000 0000",
                         cyc, result, {invalid, div_by_zero, overflow, underflow});
    end
  endtask

  task automatic test_reset_mid_divide();
    logic [31:0] res;
    logic [3:0]  fl;
    int          cyc;
    logic        bok;
    logic        seen_done;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 ||
        {invalid, div_by_zero, overflow, underflow} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid: busy=%b done=%b result=%h required 0 0 00000000",
                         busy, done, result);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0 || result !== 32'h0) begin
      n_fail++; $display("FAIL rst_no_done: activity=%b result=%h required 0 00000000",
                         seen_done, result);
    end
    run_op(32'h3F800000, 32'h40000000, 5, res, fl, cyc, bok);
    n_checks++;
    if (res !== 32'h3F000000 || fl !== 4'b0000 || cyc !== 29 || bok !== 1'b1) begin
      n_fail++; $display("FAIL rst_then_op: got %h %b lat %0d required 3F000000 0000 lat 29",
                         res, fl, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_divide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
